// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_sequencer_pkg;

  // Next-PC source, listed in decreasing priority.
  typedef enum logic [2:0] {
    SEL_RET,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_HOLD,
    SEL_SEQ
  } next_sel_e;

  // Mask of the PC bits below the fetch granule (STEP is a power of two).
  function automatic logic [63:0] align_mask(input int unsigned step);
    return 64'(step) - 64'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the pipeline and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             Stall;
  logic             BranchEn;
  logic [WIDTH-1:0] BranchTarget;
  logic             JumpEn;
  logic [WIDTH-1:0] JumpTarget;
  logic             RetEn;
  logic [WIDTH-1:0] RetTarget;
  logic             CallEn;
  logic             ClearFlags;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PCPlusStep;
  logic [CW-1:0]    RasCount;
  logic             RasHit;
  logic             Underflow;
  logic             Overflow;
  logic             Misaligned;

  modport master (
    output Stall, BranchEn, BranchTarget, JumpEn, JumpTarget,
           RetEn, RetTarget, CallEn, ClearFlags,
    input  PC, PCPlusStep, RasCount, RasHit, Underflow, Overflow, Misaligned
  );

  modport slave (
    input  Stall, BranchEn, BranchTarget, JumpEn, JumpTarget,
           RetEn, RetTarget, CallEn, ClearFlags,
    output PC, PCPlusStep, RasCount, RasHit, Underflow, Overflow, Misaligned
  );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: wrapping top pointer plus saturating count.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    ptr_inc, ptr_dec;
  logic             empty, full;

  assign top   = mem_q[ptr_q];
  assign count = count_q;

  // Pointer arithmetic and push/pop update; ptr_q always addresses the top entry.
  always_comb begin
    mem_d     = mem_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    overflow  = 1'b0;
    underflow = 1'b0;
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    ptr_inc   = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    ptr_dec   = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);
    if (push && pop) begin
      if (empty) begin
        // nothing to pop: degenerates to a plain push, but still an underflow
        ptr_d          = ptr_inc;
        mem_d[ptr_inc] = push_data;
        count_d        = CW'(1);
        underflow      = 1'b1;
      end else begin
        mem_d[ptr_q] = push_data;
      end
    end else if (push) begin
      ptr_d          = ptr_inc;
      mem_d[ptr_inc] = push_data;
      if (full) overflow = 1'b1;
      else      count_d  = count_q + CW'(1);
    end else if (pop) begin
      if (empty) begin
        underflow = 1'b1;
      end else begin
        ptr_d   = ptr_dec;
        count_d = count_q - CW'(1);
      end
    end
  end

  // Stack storage, pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter with prioritised redirect select and return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      DEPTH        = 4
) (
  input logic         Clk,
  input logic         Reset_n,
  pc_sequencer_if.slave bus
);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(align_mask(STEP));
  localparam int unsigned      CW       = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ras_hit_q, ras_hit_d;
  logic             underflow_q, underflow_d;
  logic             overflow_q, overflow_d;
  logic             misaligned_q, misaligned_d;

  logic [WIDTH-1:0] pc_plus_step;
  logic [WIDTH-1:0] raw_target;
  logic             redirect;
  next_sel_e        sel;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_count;
  logic             ras_ovf, ras_udf;

  ras_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus_step),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_ovf),
    .underflow (ras_udf)
  );

  // Next-PC selection, target alignment and sticky-flag update.
  always_comb begin
    pc_plus_step = pc_q + WIDTH'(STEP);
    sel          = SEL_SEQ;
    raw_target   = pc_plus_step;
    redirect     = 1'b0;
    if      (bus.RetEn)    sel = SEL_RET;
    else if (bus.JumpEn)   sel = SEL_JUMP;
    else if (bus.BranchEn) sel = SEL_BRANCH;
    else if (bus.Stall)    sel = SEL_HOLD;
    case (sel)
      SEL_RET: begin
        raw_target = (ras_count != '0) ? ras_top : bus.RetTarget;
        redirect   = 1'b1;
      end
      SEL_JUMP: begin
        raw_target = bus.JumpTarget;
        redirect   = 1'b1;
      end
      SEL_BRANCH: begin
        raw_target = bus.BranchTarget;
        redirect   = 1'b1;
      end
      SEL_HOLD: raw_target = pc_q;
      default:  raw_target = pc_plus_step;
    endcase
    pc_d         = raw_target & ~LOW_MASK;
    ras_pop      = bus.RetEn;
    ras_push     = bus.CallEn && (bus.RetEn || bus.JumpEn);
    ras_hit_d    = bus.RetEn && (ras_count != '0);
    underflow_d  = (underflow_q && !bus.ClearFlags) || ras_udf;
    overflow_d   = (overflow_q && !bus.ClearFlags) || ras_ovf;
    misaligned_d = (misaligned_q && !bus.ClearFlags) ||
                   (redirect && ((raw_target & LOW_MASK) != '0));
  end

  // PC and status registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q         <= RESET_VECTOR;
      ras_hit_q    <= 1'b0;
      underflow_q  <= 1'b0;
      overflow_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ras_hit_q    <= ras_hit_d;
      underflow_q  <= underflow_d;
      overflow_q   <= overflow_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.PCPlusStep = pc_plus_step;
  assign bus.RasCount   = ras_count;
  assign bus.RasHit     = ras_hit_q;
  assign bus.Underflow  = underflow_q;
  assign bus.Overflow   = overflow_q;
  assign bus.Misaligned = misaligned_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (WIDTH=32, STEP=4, RESET_VECTOR=0, DEPTH=4).
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32), .DEPTH(4)) bus_if ();

  pc_sequencer #(
    .WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .DEPTH(4)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus_if.Stall = 0; bus_if.BranchEn = 0; bus_if.BranchTarget = '0;
    bus_if.JumpEn = 0; bus_if.JumpTarget = '0; bus_if.RetEn = 0;
    bus_if.RetTarget = '0; bus_if.CallEn = 0; bus_if.ClearFlags = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] t, input logic call);
    clr_in(); bus_if.JumpEn = 1; bus_if.JumpTarget = t; bus_if.CallEn = call;
    step();
  endtask

  task automatic ret(input logic [31:0] rt, input logic call);
    clr_in(); bus_if.RetEn = 1; bus_if.RetTarget = rt; bus_if.CallEn = call;
    step();
  endtask

  task automatic flags(input string tag, input logic h, input logic u, input logic o, input logic m);
    check({tag, "_hit"}, 32'(bus_if.RasHit), 32'(h));
    check({tag, "_udf"}, 32'(bus_if.Underflow), 32'(u));
    check({tag, "_ovf"}, 32'(bus_if.Overflow), 32'(o));
    check({tag, "_mis"}, 32'(bus_if.Misaligned), 32'(m));
  endtask

  initial begin
    clr_in();
    #12;
    check("rst_pc", bus_if.PC, 32'h0);
    check("rst_pps", bus_if.PCPlusStep, 32'h4);
    check("rst_cnt", 32'(bus_if.RasCount), 0);
    flags("rst", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1;

    // sequential fetch
    step(); check("seq1", bus_if.PC, 32'h4);
    step(); check("seq2", bus_if.PC, 32'h8);
    step(); check("seq3", bus_if.PC, 32'hC);
    check("seq3_pps", bus_if.PCPlusStep, 32'h10);

    // branch overrides stall, then stall holds
    jump(32'h100, 0); check("j100", bus_if.PC, 32'h100);
    clr_in(); bus_if.Stall = 1; bus_if.BranchEn = 1; bus_if.BranchTarget = 32'h200;
    step(); check("br_stall", bus_if.PC, 32'h200);
    bus_if.BranchEn = 0;
    step(); check("stall1", bus_if.PC, 32'h200);
    step(); check("stall2", bus_if.PC, 32'h200);
    check("stall_cnt", 32'(bus_if.RasCount), 0);

    // nested call / return
    jump(32'h10, 0);  check("j10", bus_if.PC, 32'h10);
    jump(32'h400, 1); check("call1_pc", bus_if.PC, 32'h400);
    check("call1_cnt", 32'(bus_if.RasCount), 1);
    jump(32'h800, 1); check("call2_pc", bus_if.PC, 32'h800);
    check("call2_cnt", 32'(bus_if.RasCount), 2);
    ret(32'h0, 0); check("ret1_pc", bus_if.PC, 32'h404);
    check("ret1_hit", 32'(bus_if.RasHit), 1);
    check("ret1_cnt", 32'(bus_if.RasCount), 1);
    ret(32'h0, 0); check("ret2_pc", bus_if.PC, 32'h14);
    check("ret2_cnt", 32'(bus_if.RasCount), 0);
    clr_in(); step(); check("idle_pc", bus_if.PC, 32'h18);
    flags("idle", 0, 0, 0, 0);

    // underflow return, sticky until cleared
    ret(32'h3C, 0); check("udf_pc", bus_if.PC, 32'h3C);
    flags("udf", 0, 1, 0, 0);
    clr_in(); step(); check("udf_hold_pc", bus_if.PC, 32'h40);
    check("udf_sticky", 32'(bus_if.Underflow), 1);
    clr_in(); bus_if.ClearFlags = 1; step();
    check("clr_pc", bus_if.PC, 32'h44);
    check("clr_udf", 32'(bus_if.Underflow), 0);

    // overflow: five pushes into a four-deep stack
    jump(32'h0, 0);
    jump(32'h10, 1); jump(32'h20, 1); jump(32'h30, 1); jump(32'h40, 1);
    check("full_cnt", 32'(bus_if.RasCount), 4);
    check("full_ovf", 32'(bus_if.Overflow), 0);
    jump(32'h50, 1); check("ovf_pc", bus_if.PC, 32'h50);
    check("ovf_cnt", 32'(bus_if.RasCount), 4);
    check("ovf_flag", 32'(bus_if.Overflow), 1);
    ret(32'h3C, 0); check("pop1", bus_if.PC, 32'h44);
    check("pop1_cnt", 32'(bus_if.RasCount), 3);
    ret(32'h3C, 0); check("pop2", bus_if.PC, 32'h34);
    ret(32'h3C, 0); check("pop3", bus_if.PC, 32'h24);
    ret(32'h3C, 0); check("pop4", bus_if.PC, 32'h14);
    check("pop4_cnt", 32'(bus_if.RasCount), 0);
    ret(32'h3C, 0); check("pop5", bus_if.PC, 32'h3C);
    flags("pop5", 0, 1, 1, 0);

    // set event wins over clear in the same cycle
    clr_in(); bus_if.RetEn = 1; bus_if.RetTarget = 32'h3C; bus_if.ClearFlags = 1;
    step(); check("setwin_pc", bus_if.PC, 32'h3C);
    check("setwin_udf", 32'(bus_if.Underflow), 1);
    check("setwin_ovf", 32'(bus_if.Overflow), 0);
    clr_in(); bus_if.ClearFlags = 1; step();
    check("clr2_pc", bus_if.PC, 32'h40);
    check("clr2_udf", 32'(bus_if.Underflow), 0);

    // simultaneous pop+push with a non-empty stack replaces the top
    jump(32'h200, 1); check("pp_cnt0", 32'(bus_if.RasCount), 1);
    ret(32'h0, 1); check("pp_pc", bus_if.PC, 32'h44);
    check("pp_cnt", 32'(bus_if.RasCount), 1);
    check("pp_hit", 32'(bus_if.RasHit), 1);
    ret(32'h0, 0); check("pp_ret_pc", bus_if.PC, 32'h204);
    check("pp_ret_cnt", 32'(bus_if.RasCount), 0);

    // simultaneous pop+push with an empty stack
    ret(32'h80, 1); check("ppe_pc", bus_if.PC, 32'h80);
    check("ppe_cnt", 32'(bus_if.RasCount), 1);
    flags("ppe", 0, 1, 0, 0);
    ret(32'h0, 0); check("ppe_ret_pc", bus_if.PC, 32'h208);
    clr_in(); bus_if.ClearFlags = 1; step();
    check("clr3_pc", bus_if.PC, 32'h20C);

    // CallEn without ret/jump is ignored
    clr_in(); bus_if.BranchEn = 1; bus_if.BranchTarget = 32'h300; bus_if.CallEn = 1;
    step(); check("brcall_pc", bus_if.PC, 32'h300);
    check("brcall_cnt", 32'(bus_if.RasCount), 0);
    clr_in(); bus_if.CallEn = 1; step();
    check("call_only_pc", bus_if.PC, 32'h304);
    check("call_only_cnt", 32'(bus_if.RasCount), 0);

    // misaligned targets are truncated
    jump(32'h1002, 0); check("mis_pc", bus_if.PC, 32'h1000);
    flags("mis", 0, 0, 0, 1);
    ret(32'h57, 0); check("mis_ret_pc", bus_if.PC, 32'h54);
    clr_in(); bus_if.ClearFlags = 1; step();
    flags("clr4", 0, 0, 0, 0);

    // wrap-around of PC+STEP
    jump(32'hFFFF_FFFC, 0);
    check("wrap_pps", bus_if.PCPlusStep, 32'h0);
    clr_in(); step(); check("wrap_pc", bus_if.PC, 32'h0);
    check("wrap_flags", 32'(bus_if.Misaligned), 0);

    // asynchronous reset in the middle of a call sequence
    jump(32'h600, 1); check("pre_rst_cnt", 32'(bus_if.RasCount), 1);
    jump(32'h1003, 1);
    check("pre_rst_mis", 32'(bus_if.Misaligned), 1);
    #3; rst_n = 0; #1;
    check("arst_pc", bus_if.PC, 32'h0);
    check("arst_cnt", 32'(bus_if.RasCount), 0);
    flags("arst", 0, 0, 0, 0);
    clr_in(); step(); check("arst_hold_pc", bus_if.PC, 32'h0);
    @(negedge clk); rst_n = 1;
    step(); check("post_rst_pc", bus_if.PC, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
